// File: rtl/booth_operand_sequencer_if.sv
// Operand/product stream and multiplier load bus for the Booth operand sequencer.
// Latency: none; this is wiring only.
// Backpressure: in_ready and out_ready carry flow control across the bundle.
interface booth_operand_sequencer_if #(
  parameter int DATA_W = 16
);
  // operand pair stream into the sequencer
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_a;
  logic [DATA_W-1:0]     in_b;

  // serial load bus towards the multiplier, result back from it
  logic                  mul_start;
  logic [DATA_W-1:0]     mul_data;
  logic [2*DATA_W-1:0]   mul_result;

  // product stream out of the sequencer
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_result;

  logic                  busy;

  // sequencer side
  modport slave (
    input  in_valid, in_a, in_b, mul_result, out_ready,
    output in_ready, mul_start, mul_data, out_valid, out_result, busy
  );

  // environment side: producer, multiplier and consumer
  modport master (
    output in_valid, in_a, in_b, mul_result, out_ready,
    input  in_ready, mul_start, mul_data, out_valid, out_result, busy
  );
endinterface

// File: rtl/booth_operand_sequencer.sv
// Small synchronous FIFO used to buffer operand pairs ahead of the sequencer FSM.
// Latency: a pushed entry is visible at pop_dat one cycle after the push edge.
// Backpressure: full blocks pushes; a push and pop on the same edge both take effect.
module booth_seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // extra pointer bit distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // pointer advance; reset empties the buffer without touching storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// Front-end for the Booth multiplier: buffers operand pairs, runs the start/A/B load, captures the product.
// Latency: pair accepted at edge 0 -> out_valid at edge MULT_LATENCY+5 when idle and empty.
// Backpressure: in_ready low when the buffer is full; a held product stalls the FSM in CAPTURE.
module booth_operand_sequencer #(
  parameter int DATA_W       = 16,
  parameter int MULT_LATENCY = 17,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  booth_operand_sequencer_if.slave      bus
);
  localparam int CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [CNT_W-1:0]    wait_cnt;
  logic                mul_start_q;
  logic [DATA_W-1:0]   mul_data_q;
  logic                out_valid_q;
  logic [2*DATA_W-1:0] out_result_q;

  pair_t               push_pair;
  pair_t               pop_pair;
  logic                fifo_full;
  logic                fifo_empty;
  logic                capture_fire;

  assign push_pair.a = bus.in_a;
  assign push_pair.b = bus.in_b;

  booth_seq_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (bus.in_valid),
    .push_dat (push_pair),
    .pop_rdy  (state == S_IDLE),
    .pop_dat  (pop_pair),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // the output slot can take a new product if empty or emptied on this same edge
  assign capture_fire = (state == S_CAPTURE) && (!out_valid_q || bus.out_ready);

  assign bus.in_ready   = !fifo_full;
  assign bus.busy       = (state != S_IDLE) || !fifo_empty;
  assign bus.mul_start  = mul_start_q;
  assign bus.mul_data   = mul_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;

  // load sequencer: start pulse, then A, then B, then wait out the multiplier latency.
  // mul_start/mul_data are registered with the state they belong to, so the
  // multiplier never sees decode glitches and the bus idles at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      wait_cnt    <= '0;
      mul_start_q <= 1'b0;
      mul_data_q  <= '0;
    end else begin
      mul_start_q <= 1'b0;
      mul_data_q  <= '0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            op_a        <= pop_pair.a;
            op_b        <= pop_pair.b;
            mul_start_q <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          mul_data_q <= op_a;
          state      <= S_LOAD_A;
        end
        S_LOAD_A: begin
          mul_data_q <= op_b;
          state      <= S_LOAD_B;
        end
        S_LOAD_B: begin
          wait_cnt <= CNT_W'(MULT_LATENCY - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_CAPTURE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_CAPTURE: begin
          // the multiplier holds its result, so stalling here loses nothing
          if (capture_fire) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // output register: a capture overrides the drain so back-to-back products keep valid high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else if (capture_fire) begin
      out_valid_q  <= 1'b1;
      out_result_q <= bus.mul_result;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Bench for booth_operand_sequencer with a behavioural fixed-latency multiplier.
// Latency: checks the exact edge-by-edge load sequence and product arrival.
// Backpressure: exercises output stalls, full buffer, and random out_ready.
module tb_booth_operand_sequencer;
  localparam int DW  = 16;
  localparam int LAT = 17;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_operand_sequencer_if #(.DATA_W(DW)) bus ();

  booth_operand_sequencer #(
    .DATA_W       (DW),
    .MULT_LATENCY (LAT),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // multiplier model: start, then A, then B; result valid LAT edges after B is taken.
  // Until then the result bus carries garbage so an early capture is visible.
  logic signed [15:0] m_a;
  logic signed [31:0] m_prod;
  logic [1:0]         m_phase;
  int                 m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase        <= 2'd0;
      m_cnt          <= 0;
      m_a            <= '0;
      m_prod         <= '0;
      bus.mul_result <= '0;
    end else if (bus.mul_start) begin
      m_phase        <= 2'd1;
      m_cnt          <= 0;
      bus.mul_result <= 32'hDEAD_BEEF;
    end else if (m_phase == 2'd1) begin
      m_a     <= $signed(bus.mul_data);
      m_phase <= 2'd2;
    end else if (m_phase == 2'd2) begin
      m_prod  <= m_a * $signed(bus.mul_data);
      m_phase <= 2'd0;
      m_cnt   <= LAT;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) bus.mul_result <= m_prod;
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one pair from an idle, empty block; checks every edge up to the product drain
  task automatic run_single(input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp, input string name);
    logic [15:0] exp_d;
    bus.out_ready = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    check1({name, " in_ready"}, bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    for (int e = 1; e <= LAT + 5; e++) begin
      tick();
      exp_d = (e == 2) ? a : (e == 3) ? b : 16'h0;
      check1($sformatf("%s e%0d mul_start", name, e), bus.mul_start, e == 1);
      check32($sformatf("%s e%0d mul_data", name, e), {16'h0, bus.mul_data}, {16'h0, exp_d});
      check1($sformatf("%s e%0d out_valid", name, e), bus.out_valid, e == LAT + 5);
    end
    check32({name, " out_result"}, bus.out_result, exp);
    tick();
    check1({name, " drained"}, bus.out_valid, 1'b0);
    check1({name, " idle"}, bus.busy, 1'b0);
  endtask

  // wait (bounded) for a product, check it, and let it drain
  task automatic wait_out(input logic [31:0] exp, input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    check1({name, " valid"}, bus.out_valid, 1'b1);
    check32({name, " data"}, bus.out_result, exp);
    tick();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] bp_a[4];
  logic [15:0] bp_b[4];
  logic [31:0] bp_e[4];

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{16'd10,    16'd13,    32'h0000_0082, "10x13"};
    vecs[1] = '{16'hFFFD,  16'd7,     32'hFFFF_FFEB, "m3x7"};
    vecs[2] = '{16'h8000,  16'h8000,  32'h4000_0000, "min_x_min"};
    vecs[3] = '{16'h7FFF,  16'hFFFF,  32'hFFFF_8001, "max_x_m1"};
    vecs[4] = '{16'd5,     16'd6,     32'd30,        "5x6"};
    vecs[5] = '{16'hFFFF,  16'hFFFF,  32'h0000_0001, "m1xm1"};
    vecs[6] = '{16'd100,   16'hFF38,  32'hFFFF_B1E0, "100xm200"};
    vecs[7] = '{16'h0000,  16'h8000,  32'h0000_0000, "0xmin"};

    bp_a = '{16'd2, 16'hFFFC, 16'd7,  16'hFFF7};
    bp_b = '{16'd3, 16'd5,    16'hFFF8, 16'hFFF6};
    bp_e = '{32'd6, 32'hFFFF_FFEC, 32'hFFFF_FFC8, 32'd90};

    // reset state
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    #2;
    check1("rst in_ready", bus.in_ready, 1'b1);
    check1("rst out_valid", bus.out_valid, 1'b0);
    check1("rst mul_start", bus.mul_start, 1'b0);
    check32("rst mul_data", {16'h0, bus.mul_data}, 32'h0);
    check32("rst out_result", bus.out_result, 32'h0);
    check1("rst busy", bus.busy, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // directed single-pair vectors
    for (int i = 0; i < 8; i++) begin
      run_single(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end

    // backpressure: four pairs with the consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int n;
      bus.in_a     = bp_a[i];
      bus.in_b     = bp_b[i];
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 200) begin
        tick();
        n++;
      end
      check1($sformatf("bp push%0d ready", i), bus.in_ready, 1'b1);
      tick();
      if (i == 1) check1("push_pop_same_edge not_full", bus.in_ready, 1'b1);
      if (i == 2) check1("bp fifo_full", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    repeat (60) tick();
    check1("bp held valid", bus.out_valid, 1'b1);
    check32("bp held data", bus.out_result, bp_e[0]);
    check1("bp stalled in_ready", bus.in_ready, 1'b0);
    check1("bp stalled busy", bus.busy, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    check1("capture_with_drain valid", bus.out_valid, 1'b1);
    check32("capture_with_drain data", bus.out_result, bp_e[1]);
    tick();
    check1("bp p2 drained", bus.out_valid, 1'b0);
    wait_out(bp_e[2], "bp p3");
    wait_out(bp_e[3], "bp p4");
    repeat (30) tick();
    check1("bp all idle", bus.busy, 1'b0);

    // reset in WAIT with a second pair queued
    bus.out_ready = 1'b1;
    bus.in_a      = 16'd1234;
    bus.in_b      = 16'hFFFE;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_a = 16'd77;
    bus.in_b = 16'd3;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check1("pre-rst busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check1("midrst in_ready", bus.in_ready, 1'b1);
    check1("midrst out_valid", bus.out_valid, 1'b0);
    check1("midrst mul_start", bus.mul_start, 1'b0);
    check32("midrst mul_data", {16'h0, bus.mul_data}, 32'h0);
    check32("midrst out_result", bus.out_result, 32'h0);
    check1("midrst busy", bus.busy, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check1("post-rst busy", bus.busy, 1'b0);
    check1("post-rst out_valid", bus.out_valid, 1'b0);
    run_single(16'd5, 16'd6, 32'd30, "after_rst 5x6");

    // random pairs under random out_ready, against an a*b scoreboard
    begin
      logic [31:0] q[$];
      int sent;
      int recv;
      int cyc;
      int pa;
      int pb;
      sent = 0;
      recv = 0;
      cyc  = 0;
      while (recv < 1000 && cyc < 60000) begin
        if (sent < 1000) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          bus.in_a     = 16'($urandom);
          bus.in_b     = 16'($urandom);
        end else begin
          bus.in_valid = 1'b0;
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
        if (bus.in_valid && bus.in_ready) begin
          pa = $signed(bus.in_a);
          pb = $signed(bus.in_b);
          q.push_back(32'(pa * pb));
          sent++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check1("rand unexpected product", 1'b1, 1'b0);
          end else begin
            check32($sformatf("rand product %0d", recv), bus.out_result, q.pop_front());
          end
          recv++;
        end
        tick();
        cyc++;
      end
      bus.in_valid = 1'b0;
      check32("rand products received", 32'(recv), 32'd1000);
      check32("rand scoreboard empty", 32'(q.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
